// File: rtl/vga_timing_generator_pkg.sv
// Shared VGA 640x480@60 timing constants and pipeline types.
package vga_timing_generator_pkg;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned FRAME_WIDTH  = H_ACTIVE;
  localparam int unsigned FRAME_HEIGHT = V_ACTIVE;

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned COORD_W = 12;

  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, active: 1'b0};
endpackage

// File: rtl/vga_timing_generator_delay_line.sv
// Parameterised width/depth shift register with a configurable reset value.
module vga_delay_line #(
  parameter int unsigned       WIDTH     = 1,
  parameter int unsigned       DEPTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = d;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RESET_VAL;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[DEPTH-1];
endmodule

// File: rtl/vga_timing_generator.sv
// VGA timing generator: counters, 1-based x/y, colour capture with blanking,
// and sync outputs aligned to the same pixel as RGB.
module vga_timing_generator #(
  parameter int unsigned H_ACTIVE      = vga_timing_generator_pkg::H_ACTIVE,
  parameter int unsigned H_FP          = vga_timing_generator_pkg::H_FP,
  parameter int unsigned H_SYNC        = vga_timing_generator_pkg::H_SYNC,
  parameter int unsigned H_BP          = vga_timing_generator_pkg::H_BP,
  parameter int unsigned V_ACTIVE      = vga_timing_generator_pkg::V_ACTIVE,
  parameter int unsigned V_FP          = vga_timing_generator_pkg::V_FP,
  parameter int unsigned V_SYNC        = vga_timing_generator_pkg::V_SYNC,
  parameter int unsigned V_BP          = vga_timing_generator_pkg::V_BP,
  parameter int unsigned COLOR_LATENCY = 0
) (
  input  logic        CLOCK_25,
  input  logic        reset,
  input  logic [2:0]  color,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        vga_r,
  output logic        vga_g,
  output logic        vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        frame_tick
);
  import vga_timing_generator_pkg::*;

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [CNT_W-1:0]   h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [2:0]         rgb_q, rgb_d;
  logic               hs_q, hs_d, vs_q, vs_d;
  logic               frame_tick_q, frame_tick_d;
  logic               active;
  sync_t              sync_raw, sync_dly;

  always_comb begin
    h_cnt_d = h_cnt_q + CNT_W'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == CNT_W'(H_TOT - 1)) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == CNT_W'(V_TOT - 1)) ? '0 : v_cnt_q + CNT_W'(1);
    end

    active = (h_cnt_q < CNT_W'(H_ACTIVE)) && (v_cnt_q < CNT_W'(V_ACTIVE));
    x_d    = active ? COORD_W'(h_cnt_q) + COORD_W'(1) : '0;
    y_d    = active ? COORD_W'(v_cnt_q) + COORD_W'(1) : '0;

    sync_raw.hs     = !((h_cnt_q >= CNT_W'(H_ACTIVE + H_FP)) &&
                        (h_cnt_q <  CNT_W'(H_ACTIVE + H_FP + H_SYNC)));
    sync_raw.vs     = !((v_cnt_q >= CNT_W'(V_ACTIVE + V_FP)) &&
                        (v_cnt_q <  CNT_W'(V_ACTIVE + V_FP + V_SYNC)));
    sync_raw.active = active;

    frame_tick_d = (h_cnt_q == '0) && (v_cnt_q == CNT_W'(V_ACTIVE));

    rgb_d = sync_dly.active ? color : '0;
    hs_d  = sync_dly.hs;
    vs_d  = sync_dly.vs;
  end

  // The delay line holds 1+COLOR_LATENCY stages so that active lines up with
  // the colour sample; the output register supplies the final stage for all.
  vga_delay_line #(
    .WIDTH    ($bits(sync_t)),
    .DEPTH    (1 + COLOR_LATENCY),
    .RESET_VAL(SYNC_IDLE)
  ) u_sync_dly (
    .clk  (CLOCK_25),
    .reset(reset),
    .d    (sync_raw),
    .q    (sync_dly)
  );

  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      rgb_q        <= '0;
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      rgb_q        <= rgb_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign vga_r      = rgb_q[2];
  assign vga_g      = rgb_q[1];
  assign vga_b      = rgb_q[0];
  assign vga_hs     = hs_q;
  assign vga_vs     = vs_q;
  assign frame_tick = frame_tick_q;
endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: full-size and reduced-timing instances
// checked every cycle against a position-based model plus literal pins.
module tb_vga_timing_generator;
  typedef struct {
    int ha, hfp, hs, hbp, va, vfp, vs, vbp, lat;
  } cfg_t;

  localparam cfg_t CFG_F  = '{640, 16, 96, 48, 480, 10, 2, 33, 0};
  localparam cfg_t CFG_S0 = '{16, 2, 4, 3, 6, 2, 2, 3, 0};
  localparam cfg_t CFG_S2 = '{16, 2, 4, 3, 6, 2, 2, 3, 2};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmode = 1'b0;
  logic mode_m = 1'b0;
  int   n = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  always #20 clk = ~clk;

  logic [11:0] x_f, y_f, x_s0, y_s0, x_s2, y_s2;
  logic        r_f, g_f, b_f, hs_f, vs_f, tk_f;
  logic        r_s0, g_s0, b_s0, hs_s0, vs_s0, tk_s0;
  logic        r_s2, g_s2, b_s2, hs_s2, vs_s2, tk_s2;
  logic [2:0]  col_f, col_s0, col_s2, gen1, gen2;

  assign col_f  = cmode ? 3'b101 : x_f[2:0];
  assign col_s0 = cmode ? 3'b101 : x_s0[2:0];
  // Image generator with two cycles of latency for the COLOR_LATENCY=2 instance.
  always @(posedge clk) begin
    gen1 <= cmode ? 3'b101 : x_s2[2:0];
    gen2 <= gen1;
  end
  assign col_s2 = gen2;

  vga_timing_generator dut_f (
    .CLOCK_25(clk), .reset(reset), .color(col_f), .x(x_f), .y(y_f),
    .vga_r(r_f), .vga_g(g_f), .vga_b(b_f), .vga_hs(hs_f), .vga_vs(vs_f),
    .frame_tick(tk_f)
  );

  vga_timing_generator #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .COLOR_LATENCY(0)
  ) dut_s0 (
    .CLOCK_25(clk), .reset(reset), .color(col_s0), .x(x_s0), .y(y_s0),
    .vga_r(r_s0), .vga_g(g_s0), .vga_b(b_s0), .vga_hs(hs_s0), .vga_vs(vs_s0),
    .frame_tick(tk_s0)
  );

  vga_timing_generator #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .COLOR_LATENCY(2)
  ) dut_s2 (
    .CLOCK_25(clk), .reset(reset), .color(col_s2), .x(x_s2), .y(y_s2),
    .vga_r(r_s2), .vga_g(g_s2), .vga_b(b_s2), .vga_hs(hs_s2), .vga_vs(vs_s2),
    .frame_tick(tk_s2)
  );

  // n = cycles since the last reset-sampled edge; the counter position at
  // cycle n is n itself (mod frame length).
  always @(posedge clk) begin
    if (reset) begin
      n      <= 0;
      mode_m <= cmode;
    end else begin
      n <= n + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s n=%0d actual=%0h expected=%0h", nm, n, act, exp);
    end
  endtask

  task automatic check_dut(input string tag, input cfg_t c,
                           input logic [11:0] ax, input logic [11:0] ay,
                           input logic [2:0] argb, input logic ahs,
                           input logic avs, input logic atk);
    int ht, vt, p, h, v;
    logic [11:0] ex, ey;
    logic [2:0]  ergb;
    logic        ehs, evs, etk;
    ht = c.ha + c.hfp + c.hs + c.hbp;
    vt = c.va + c.vfp + c.vs + c.vbp;
    ex = '0; ey = '0; etk = 1'b0;
    p = n - 1;
    if (p >= 0) begin
      h = p % ht;
      v = (p / ht) % vt;
      if (h < c.ha && v < c.va) begin
        ex = 12'(h + 1);
        ey = 12'(v + 1);
      end
      etk = (h == 0 && v == c.va);
    end
    ergb = '0; ehs = 1'b1; evs = 1'b1;
    p = n - 2 - c.lat;
    if (p >= 0) begin
      h = p % ht;
      v = (p / ht) % vt;
      ehs = !(h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hs);
      evs = !(v >= c.va + c.vfp && v < c.va + c.vfp + c.vs);
      if (h < c.ha && v < c.va) ergb = mode_m ? 3'b101 : 3'((h + 1) % 8);
    end
    chk({tag, ".x"}, 32'(ax), 32'(ex));
    chk({tag, ".y"}, 32'(ay), 32'(ey));
    chk({tag, ".rgb"}, 32'(argb), 32'(ergb));
    chk({tag, ".hs"}, 32'(ahs), 32'(ehs));
    chk({tag, ".vs"}, 32'(avs), 32'(evs));
    chk({tag, ".tick"}, 32'(atk), 32'(etk));
  endtask

  always @(negedge clk) begin
    check_dut("full", CFG_F, x_f, y_f, {r_f, g_f, b_f}, hs_f, vs_f, tk_f);
    check_dut("s0", CFG_S0, x_s0, y_s0, {r_s0, g_s0, b_s0}, hs_s0, vs_s0, tk_s0);
    check_dut("s2", CFG_S2, x_s2, y_s2, {r_s2, g_s2, b_s2}, hs_s2, vs_s2, tk_s2);
  end

  // Event recorders for literal timing checks.
  logic rec = 1'b0;
  logic hs_prev = 1'b1;
  int f_fall1 = -1, f_fall2 = -1, f_low = 0, f_px = -1;
  int s_t1 = -1, s_t2 = -1, s_vlow = 0, s2_px = -1;
  logic [2:0] s2_pxv = '0;

  always @(negedge clk) begin
    if (rec) begin
      if (hs_prev && !hs_f) begin
        if (f_fall1 < 0) f_fall1 = n;
        else if (f_fall2 < 0) f_fall2 = n;
      end
      if (!hs_f && n < 800) f_low++;
      if (n > 700 && f_px < 0 && {r_f, g_f, b_f} != 3'b000) f_px = n;
      if (tk_s0) begin
        if (s_t1 < 0) s_t1 = n;
        else if (s_t2 < 0) s_t2 = n;
      end
      if (!vs_s0 && n < 325) s_vlow++;
      if (s2_px < 0 && {r_s2, g_s2, b_s2} != 3'b000) begin
        s2_px  = n;
        s2_pxv = {r_s2, g_s2, b_s2};
      end
      hs_prev = hs_f;
    end
  end

  initial begin
    reset = 1'b1;
    cmode = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst.x", 32'(x_f), 32'd0);
    chk("rst.hs", 32'(hs_f), 32'd1);
    chk("rst.rgb", 32'({r_f, g_f, b_f}), 32'd0);
    rec   = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    chk("first.x", 32'(x_f), 32'd1);
    chk("first.y", 32'(y_f), 32'd1);
    repeat (1700) @(negedge clk);
    rec = 1'b0;
    chk("hs_first_fall", 32'(f_fall1), 32'd658);
    chk("hs_fall_period", 32'(f_fall2 - f_fall1), 32'd800);
    chk("hs_low_width", 32'(f_low), 32'd96);
    chk("hs_fall_to_first_px", 32'(f_px - f_fall1), 32'd144);
    chk("tick_first", 32'(s_t1), 32'd151);
    chk("tick_period", 32'(s_t2 - s_t1), 32'd325);
    chk("vs_low_width", 32'(s_vlow), 32'd50);
    chk("lat2_first_px_n", 32'(s2_px), 32'd4);
    chk("lat2_first_px_val", 32'(s2_pxv), 32'd1);

    // One-cycle reset mid-frame: sequence restarts from position 0.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst.x", 32'(x_s0), 32'd1);
    chk("midrst.y", 32'(y_s0), 32'd1);
    repeat (600) @(negedge clk);

    cmode = 1'b1;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (1700) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
